// File: rtl/mux_n_seq.sv
// N-input registered channel selector: static level select or a timed,
// repeating sweep over channels 0..L-1 started by a run pulse.
module mux_n_seq #(
    parameter  int DATA_W = 32,
    parameter  int N_IN   = 4,
    parameter  int CNT_W  = 8,
    localparam int SEL_W  = $clog2(N_IN)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       sel,
    input  logic [SEL_W:0]         seq_len,
    input  logic [CNT_W-1:0]       hold,
    input  logic [CNT_W-1:0]       iters,
    input  logic [N_IN*DATA_W-1:0] in_flat,
    output logic [DATA_W-1:0]      out0,
    output logic [SEL_W-1:0]       out_idx,
    output logic                   out_valid,
    output logic                   done
);

    localparam int             N_PAD = 1 << SEL_W;
    localparam logic [SEL_W:0] N_VAL = (SEL_W+1)'(N_IN);

    typedef enum logic {IDLE, SEQ} state_t;

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   idx, idx_nxt;
    logic [SEL_W-1:0]   last_idx, last_idx_nxt;
    logic [CNT_W-1:0]   hold_cnt, hold_cnt_nxt;
    logic [CNT_W-1:0]   hold_last, hold_last_nxt;
    logic [CNT_W-1:0]   sweep_cnt, sweep_cnt_nxt;
    logic [CNT_W-1:0]   iters_cfg, iters_cfg_nxt;
    logic [DATA_W-1:0]  out0_nxt;
    logic [SEL_W-1:0]   out_idx_nxt;
    logic               out_valid_nxt, done_nxt;
    logic [SEL_W:0]     len_clamp;
    logic               sel_ok;

    // Pad the channel array to a power of two so unused selects read zero.
    logic [DATA_W-1:0] chan [N_PAD];
    genvar k;
    generate
        for (k = 0; k < N_PAD; k++) begin : g_chan
            if (k < N_IN) begin : g_in
                assign chan[k] = in_flat[k*DATA_W +: DATA_W];
            end else begin : g_pad
                assign chan[k] = '0;
            end
        end
    endgenerate

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        last_idx_nxt  = last_idx;
        hold_cnt_nxt  = hold_cnt;
        hold_last_nxt = hold_last;
        sweep_cnt_nxt = sweep_cnt;
        iters_cfg_nxt = iters_cfg;
        out0_nxt      = out0;
        out_idx_nxt   = out_idx;
        out_valid_nxt = 1'b0;
        done_nxt      = done;

        len_clamp = (seq_len == '0 || seq_len > N_VAL) ? N_VAL : seq_len;
        sel_ok    = {1'b0, sel} < N_VAL;

        if (!mode) begin
            state_nxt   = IDLE;
            done_nxt    = 1'b1;
            out0_nxt    = chan[sel];
            out_idx_nxt = sel_ok ? sel : '0;
        end else if (run) begin
            // Start or restart: counters cleared, configuration captured.
            state_nxt     = SEQ;
            done_nxt      = 1'b0;
            idx_nxt       = '0;
            hold_cnt_nxt  = '0;
            sweep_cnt_nxt = '0;
            last_idx_nxt  = SEL_W'(len_clamp - 1'b1);
            hold_last_nxt = (hold == '0) ? '0 : hold - CNT_W'(1);
            iters_cfg_nxt = iters;
        end else if (state == SEQ) begin
            out0_nxt      = chan[idx];
            out_idx_nxt   = idx;
            out_valid_nxt = 1'b1;
            if (hold_cnt == hold_last) begin
                hold_cnt_nxt = '0;
                if (idx == last_idx) begin
                    idx_nxt       = '0;
                    sweep_cnt_nxt = sweep_cnt + CNT_W'(1);
                    if (iters_cfg != '0 && sweep_cnt == iters_cfg - CNT_W'(1)) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    idx_nxt = idx + SEL_W'(1);
                end
            end else begin
                hold_cnt_nxt = hold_cnt + CNT_W'(1);
            end
        end else begin
            done_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            last_idx  <= '0;
            hold_cnt  <= '0;
            hold_last <= '0;
            sweep_cnt <= '0;
            iters_cfg <= '0;
            out0      <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
            done      <= 1'b1;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            last_idx  <= last_idx_nxt;
            hold_cnt  <= hold_cnt_nxt;
            hold_last <= hold_last_nxt;
            sweep_cnt <= sweep_cnt_nxt;
            iters_cfg <= iters_cfg_nxt;
            out0      <= out0_nxt;
            out_idx   <= out_idx_nxt;
            out_valid <= out_valid_nxt;
            done      <= done_nxt;
        end
    end

endmodule
